p_t_serializer: RTL

Transmit-side byte serializer for the packed `p::p_t` struct, which is `{byte a; byte b;}`. It accepts whole `p_t` words on a valid/ready input and buffers them in a small FIFO. Each word is emitted as two bytes on a valid/ready byte stream: field `a` first, then field `b`. The block is the upstream producer for any byte-stream consumer that reassembles `p_t` words, and it is also a synthesis check for struct-typed ports driving sequential logic.

---
 rtl/p_t_serializer.sv | 159 +++++++++++++++
 1 files changed

// File: rtl/p_t_serializer.sv
package p;
  typedef struct packed {
    logic [7:0] a;
    logic [7:0] b;
  } p_t;
endpackage

// Generic word FIFO with power-of-two depth and the head word visible combinationally.
// Latency: a word pushed on an edge is at the head after that edge.
// Backpressure: full is taken from start-of-cycle occupancy, so a same-cycle pop never admits a push.
module p_t_fifo #(
  parameter int DEPTH = 2,
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic             full,
  output logic             empty
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] DEPTH_CNT = DEPTH[AW:0];
  localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic [AW:0]      count;

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  assign count = wr_ptr - rd_ptr;
  assign full  = (count == DEPTH_CNT);
  assign empty = (count == '0);
  assign head  = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_ONE;
      if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr[AW-1:0]] <= push_data;
  end
endmodule

// Serializes p_t words into a byte stream, field a first, then b (flagged last).
// Latency: a word pushed into an empty idle block shows byte a one edge later; 1 byte/cycle sustained.
// Backpressure: out_ready low freezes the output byte; in_ready drops once DEPTH words are queued.
module p_t_serializer #(
  parameter int          DEPTH      = 2,
  parameter logic [15:0] COUNT_INIT = 16'h0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  p::p_t       in_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [7:0]  out_data,
  output logic        out_last,
  output logic [15:0] word_count,
  output logic        busy
);
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SEND_A = 2'd1,
    SEND_B = 2'd2
  } state_t;

  state_t      state;
  p::p_t       head;
  logic [15:0] head_bits;
  logic [7:0]  hold_b;
  logic        fifo_full;
  logic        fifo_empty;
  logic        push;
  logic        pop;

  assign in_ready = !fifo_full && !rst;
  assign push     = in_valid && in_ready;
  // Pop when starting from idle, or when b is accepted and another word waits.
  assign pop      = !fifo_empty && ((state == IDLE) || ((state == SEND_B) && out_ready));
  assign head     = head_bits;
  assign busy     = !fifo_empty || (state != IDLE);

  p_t_fifo #(
    .DEPTH (DEPTH),
    .WIDTH ($bits(p::p_t))
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_data (in_data),
    .pop       (pop),
    .head      (head_bits),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  // Byte a goes straight to the output register on the pop, so only b needs holding.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      hold_b     <= '0;
      out_valid  <= 1'b0;
      out_data   <= '0;
      out_last   <= 1'b0;
      word_count <= COUNT_INIT;
    end else begin
      case (state)
        IDLE: begin
          if (pop) begin
            state     <= SEND_A;
            hold_b    <= head.b;
            out_valid <= 1'b1;
            out_data  <= head.a;
            out_last  <= 1'b0;
          end
        end
        SEND_A: begin
          if (out_ready) begin
            state    <= SEND_B;
            out_data <= hold_b;
            out_last <= 1'b1;
          end
        end
        SEND_B: begin
          if (out_ready) begin
            word_count <= word_count + 16'd1;
            if (pop) begin
              state    <= SEND_A;
              hold_b   <= head.b;
              out_data <= head.a;
              out_last <= 1'b0;
            end else begin
              state     <= IDLE;
              out_valid <= 1'b0;
              out_last  <= 1'b0;
            end
          end
        end
        default: begin
          state     <= IDLE;
          out_valid <= 1'b0;
          out_last  <= 1'b0;
        end
      endcase
    end
  end
endmodule
